// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single-port instruction/data RAM between
// instruction fetch (IF) and the load/store unit (LS). LS has fixed priority,
// but IF takes over once it has been denied MAX_WAIT cycles in a row. Read
// data is steered back to its owner by a tag pipeline as deep as the RAM
// read latency, so responses need no extra register stage.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH  = 31,
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_WAIT    = 4
) (
    input  logic                    clk,
    input  logic                    a_reset,

    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,

    input  logic                    ls_req,
    input  logic                    ls_we,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_be,
    output logic                    ls_gnt,
    output logic                    ls_rvalid,
    output logic [DATA_WIDTH-1:0]   ls_rdata,

    output logic                    ram_en,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic [DATA_WIDTH/8-1:0] ram_be,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    localparam int CNT_WIDTH = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_WIDTH-1:0] WAIT_LIMIT = CNT_WIDTH'(MAX_WAIT);

    // Owner encoding carried through the tag pipeline
    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_t;

    logic [CNT_WIDTH-1:0]   wait_cnt;
    logic                   if_win;
    logic                   ls_win;
    logic [RAM_LATENCY-1:0] tag_valid;
    owner_t                 tag_owner [RAM_LATENCY];

    // Pick the winner: LS by default, IF when alone or once it has starved long enough
    always_comb begin
        if_win = 1'b0;
        ls_win = 1'b0;
        if (!a_reset) begin
            if (if_req && (!ls_req || (wait_cnt >= WAIT_LIMIT))) begin
                if_win = 1'b1;
            end else if (ls_req) begin
                ls_win = 1'b1;
            end
        end
    end

    assign if_gnt = if_win;
    assign ls_gnt = ls_win;
    assign ram_en = if_win | ls_win;

    // Steer the winner's payload to the RAM; a fetch never writes or enables bytes
    always_comb begin
        ram_we    = ls_win & ls_we;
        ram_addr  = if_win ? if_addr : ls_addr;
        ram_wdata = ls_wdata;
        ram_be    = ls_win ? ls_be : '0;
    end

    // Count consecutive denied IF cycles, saturating at the starvation limit
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            wait_cnt <= '0;
        end else if (if_win) begin
            wait_cnt <= '0;
        end else if (if_req && (wait_cnt < WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
        end
    end

    // Track who owns each outstanding read so data returns to the right port
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            tag_valid <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                tag_owner[i] <= OWNER_IF;
            end
        end else begin
            tag_valid[0] <= ram_en & ~ram_we;
            tag_owner[0] <= ls_win ? OWNER_LS : OWNER_IF;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_owner[i] <= tag_owner[i-1];
            end
        end
    end

    assign if_rvalid = tag_valid[RAM_LATENCY-1] & (tag_owner[RAM_LATENCY-1] == OWNER_IF);
    assign ls_rvalid = tag_valid[RAM_LATENCY-1] & (tag_owner[RAM_LATENCY-1] == OWNER_LS);
    assign if_rdata  = ram_rdata;
    assign ls_rdata  = ram_rdata;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the CPU's single-port instruction/data RAM between two requesters: instruction fetch (IF) and load/store unit (LS).
- Sits between the CPU core and the RAM model that holds the firmware image.
- Grants one request per cycle using fixed priority to LS, with a starvation limit that guarantees IF forward progress.
- Routes RAM read data back to the owning requester through an in-flight tag pipeline that matches the RAM read latency.

Parameters:
ADDR_WIDTH, 31, word address width of the RAM.
DATA_WIDTH, 32, data word width.
RAM_LATENCY, 1, cycles from ram_en to valid ram_rdata; must be at least 1.
MAX_WAIT, 4, consecutive denied IF cycles after which IF takes priority over LS.

Ports:
clk  in  1  system clock, rising edge.
a_reset  in  1  asynchronous reset, active-high.
if_req  in  1  IF read request.
if_addr  in  ADDR_WIDTH  IF word address.
if_gnt  out  1  IF request accepted this cycle.
if_rvalid  out  1  if_rdata valid.
if_rdata  out  DATA_WIDTH  fetched word.
ls_req  in  1  LS request.
ls_we  in  1  1 = write, 0 = read.
ls_addr  in  ADDR_WIDTH  LS word address.
ls_wdata  in  DATA_WIDTH  write data.
ls_be  in  DATA_WIDTH/8  byte enables, writes only.
ls_gnt  out  1  LS request accepted this cycle.
ls_rvalid  out  1  ls_rdata valid; reads only.
ls_rdata  out  DATA_WIDTH  load data.
ram_en  out  1  RAM access strobe.
ram_we  out  1  RAM write enable.
ram_addr  out  ADDR_WIDTH  RAM address.
ram_wdata  out  DATA_WIDTH  RAM write data.
ram_be  out  DATA_WIDTH/8  RAM byte enables.
ram_rdata  in  DATA_WIDTH  RAM read data, RAM_LATENCY cycles after ram_en.

Behaviour:
- Handshake: a requester holds req and its payload stable until it sees gnt high at a rising edge. The transfer completes on that edge. Req may drop in the cycle after the grant or stay high for back-to-back requests.
- Grant is combinational from the requests and the registered starvation state.
  - At most one gnt is high per cycle.
  - ram_en = if_gnt | ls_gnt.
  - The RAM payload (addr, we, wdata, be) is muxed from the winner.
  - When there is no winner, ram_we = 0 and the payload is don't-care.
  - if_gnt forces ram_we = 0 and ram_be = 0.
- Arbitration:
  - Only one requester active: that requester wins.
  - Both active and wait_cnt < MAX_WAIT: LS wins.
  - Both active and wait_cnt >= MAX_WAIT: IF wins.
- wait_cnt, registered, width clog2(MAX_WAIT+1):
  - increments (saturating at MAX_WAIT) in each cycle where if_req=1 and if_gnt=0;
  - clears on if_gnt;
  - holds while if_req=0.
- Throughput: one access per cycle with no bubbles. Back-to-back grants to either side are legal.
- Tag pipeline: a shift register of depth RAM_LATENCY.
  - Each entry is {valid, owner}.
  - An entry is pushed each cycle with valid = ram_en & ~ram_we and owner = IF/LS.
  - At the tail: if_rvalid = valid & owner==IF, and ls_rvalid = valid & owner==LS.
  - Both rdata outputs are driven by ram_rdata directly (no extra register). Zero extra latency beyond RAM_LATENCY.
- Responses return in grant order. Writes produce no rvalid.
- Reset (a_reset=1, asynchronous):
  - tag pipeline valids cleared and wait_cnt = 0 immediately;
  - if_gnt, ls_gnt, ram_en, ram_we forced 0 while asserted;
  - if_rvalid, ls_rvalid = 0; if_rdata, ls_rdata don't-care.
- Reset asserted mid-access: in-flight reads are discarded and never produce rvalid, even after reset releases.
- First grant is possible in the first cycle after a_reset deasserts.
- Simultaneous grant and tail response in the same cycle is normal pipelined operation; no interaction between them.

Test Plan:
1. Reset, then IF alone reads addr 0x10 with the RAM holding 0x00000013 there -> if_gnt at cycle 0, if_rvalid with if_rdata=0x00000013 at cycle RAM_LATENCY; ls_rvalid stays 0.
2. if_req and ls_req (read of 0x40) both held continuously with MAX_WAIT=4 -> grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF...; wait_cnt peaks at 4; each rvalid is routed to the matching owner.
3. LS write addr 0x20, wdata 0xDEADBEEF, be 0b0011, then LS read of 0x20 over an initial 0 -> read returns 0x0000BEEF; the write itself produces no rvalid.
4. Alternating IF/LS reads every cycle with RAM_LATENCY=2 -> one ram_en per cycle, and rvalids alternate between IF and LS two cycles after each grant with correct data.
5. Assert a_reset for half a cycle while two reads are in flight -> no rvalid ever appears for them; gnt and ram_en drop asynchronously; a fresh IF read after release completes normally.
6. if_req held while ls_req is low -> IF is granted every cycle and wait_cnt stays 0.
